// File: rtl/nes_line_doubler.sv
// Ping-pong line buffer that scan-doubles 256-pixel PPU lines into a centred
// 512x480 VGA window and emits 6-bit palette addresses for the colour ROM.
module nes_line_doubler #(
  parameter logic [9:0] H_OFFSET     = 10'd64,
  parameter logic [5:0] BORDER_INDEX = 6'h0F
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic       wr_sof,
  input  logic [5:0] wr_index,
  input  logic       pix_ce,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [5:0] pal_addr,
  output logic       pal_active,
  output logic       underrun,
  output logic       synced
);

  // Handshake: a pixel transfers on a Clk edge where wr_valid && wr_ready.
  // wr_ready depends only on registered bank state, never on wr_valid.

  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_state_t;

  bank_state_t st [2];
  logic [1:0]  bank_sof;
  logic        wr_bank;
  logic        rd_ptr;   // oldest unconsumed bank in PPU write order
  logic        rd_bank;  // bank currently being displayed when one is READING

  logic [5:0]  ram0 [256];
  logic [5:0]  ram1 [256];

  logic        wr_fire;
  logic        pair_start;
  logic        rd_exists;
  logic        other_full;
  logic        other_sof;
  logic        x_in_win;

  logic        s1_vld;
  logic        s1_in_win;
  logic [7:0]  s1_addr;
  logic        s1_bank;
  logic [5:0]  rd_data;

  assign wr_ready   = (st[wr_bank] == FREE) || (st[wr_bank] == FILLING);
  assign wr_fire    = wr_valid && wr_ready;
  assign pair_start = pix_ce && (DrawX == 10'd0) && !DrawY[0] && (DrawY < 10'd480);
  assign rd_exists  = (st[0] == READING) || (st[1] == READING);
  assign other_full = (st[rd_ptr] == FULL);
  assign other_sof  = bank_sof[rd_ptr];
  assign x_in_win   = (DrawX >= H_OFFSET) && (DrawX <= H_OFFSET + 10'd511);

  // Bank bookkeeping. The write side only touches FREE/FILLING banks and the
  // pair-start logic only touches FULL/READING banks, so the two never collide.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st[0]    <= FREE;
      st[1]    <= FREE;
      bank_sof <= 2'b00;
      wr_bank  <= 1'b0;
      rd_ptr   <= 1'b0;
      rd_bank  <= 1'b0;
      synced   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (pair_start) begin
        if (DrawY == 10'd0) begin
          if (rd_exists) st[rd_bank] <= FREE;
          if (other_full && other_sof) begin
            st[rd_ptr] <= READING;
            rd_bank    <= rd_ptr;
            rd_ptr     <= ~rd_ptr;
            synced     <= 1'b1;
          end else if (other_full) begin
            st[rd_ptr] <= FREE;
            rd_ptr     <= ~rd_ptr;
            synced     <= 1'b0;
          end else begin
            synced   <= 1'b0;
            underrun <= synced;
          end
        end else if (synced) begin
          if (other_full && !other_sof) begin
            st[rd_bank] <= FREE;
            st[rd_ptr]  <= READING;
            rd_bank     <= rd_ptr;
            rd_ptr      <= ~rd_ptr;
          end else if (!other_full) begin
            underrun <= 1'b1;
          end
        end else if (other_full && !other_sof) begin
          st[rd_ptr] <= FREE;
          rd_ptr     <= ~rd_ptr;
        end
      end
      if (wr_fire) begin
        if (wr_x == 8'd0) begin
          st[wr_bank]       <= FILLING;
          bank_sof[wr_bank] <= wr_sof;
        end
        if (wr_x == 8'd255) begin
          st[wr_bank] <= FULL;
          wr_bank     <= ~wr_bank;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_fire && !wr_bank) ram0[wr_x] <= wr_index;
    if (wr_fire &&  wr_bank) ram1[wr_x] <= wr_index;
  end

  always_comb begin
    rd_data = ram0[s1_addr];
    if (s1_bank) rd_data = ram1[s1_addr];
  end

  // Two-tick read pipeline: stage 1 decides the window and address, stage 2
  // reads the line RAM and muxes in the border colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld     <= 1'b0;
      s1_in_win  <= 1'b0;
      s1_addr    <= 8'd0;
      s1_bank    <= 1'b0;
      pal_addr   <= 6'h00;
      pal_active <= 1'b0;
    end else if (pix_ce) begin
      s1_vld    <= 1'b1;
      s1_in_win <= x_in_win && (DrawY < 10'd480) && rd_exists;
      s1_addr   <= 8'((DrawX[8:0] - H_OFFSET[8:0]) >> 1);
      s1_bank   <= rd_bank;
      if (s1_vld) begin
        pal_active <= s1_in_win;
        pal_addr   <= s1_in_win ? rd_data : BORDER_INDEX;
      end
    end
  end

endmodule

// File: tb/tb_nes_line_doubler.sv
// Directed scenario walk with random pixel data and write gaps, checked
// against a line-queue model of the scan doubler.
module tb_nes_line_doubler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = 8'd0;
  logic       wr_sof = 1'b0;
  logic [5:0] wr_index = 6'd0;
  logic       pix_ce = 1'b0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [5:0] pal_addr;
  logic       pal_active;
  logic       underrun;
  logic       synced;

  always #5 Clk = ~Clk;

  nes_line_doubler dut (
    .Clk(Clk), .Reset(Reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_sof(wr_sof),
    .wr_index(wr_index), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
    .pal_addr(pal_addr), .pal_active(pal_active), .underrun(underrun),
    .synced(synced)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: PPU lines by id, a queue of completed lines waiting
  // to be shown, and the line currently on screen (-1 when none).
  logic [5:0] line_mem [16][256];
  bit         line_sof [16];
  int         comp_q[$];
  int         showing = -1;
  bit         m_synced = 1'b0;
  logic [6:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit model_ready();
    int used;
    used = comp_q.size() + ((showing >= 0) ? 1 : 0);
    return used < 2;
  endfunction

  task automatic write_pixels(input int id, input int first, input int last);
    int cnt;
    for (int x = first; x <= last; x++) begin
      while ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid = 1'b1;
      wr_x     = 8'(x);
      wr_index = line_mem[id][x];
      wr_sof   = line_sof[id];
      cnt = 0;
      while (!wr_ready && cnt < 64) begin
        tick();
        cnt++;
      end
      if (!wr_ready) begin
        check("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
        break;
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic write_line(input int id);
    check("wr_ready_pre", {31'd0, wr_ready}, {31'd0, model_ready()});
    write_pixels(id, 0, 255);
    comp_q.push_back(id);
  endtask

  task automatic vga_tick(input int x, input int y);
    logic [6:0] e;
    bit exp_u;
    int h;
    exp_u = 1'b0;
    if (showing >= 0 && x >= 64 && x <= 575 && y < 480)
      e = {1'b1, line_mem[showing][(x - 64) / 2]};
    else
      e = {1'b0, 6'h0F};
    exp_q.push_back(e);
    if (x == 0 && (y % 2) == 0 && y < 480) begin
      if (y == 0) begin
        showing = -1;
        if (comp_q.size() > 0) begin
          h = comp_q.pop_front();
          if (line_sof[h]) begin
            showing  = h;
            m_synced = 1'b1;
          end else begin
            m_synced = 1'b0;
          end
        end else begin
          exp_u    = m_synced;
          m_synced = 1'b0;
        end
      end else if (m_synced) begin
        if (comp_q.size() == 0) exp_u = 1'b1;
        else if (!line_sof[comp_q[0]]) showing = comp_q.pop_front();
      end else if (comp_q.size() > 0 && !line_sof[comp_q[0]]) begin
        void'(comp_q.pop_front());
      end
    end
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
    check("underrun", {31'd0, underrun}, {31'd0, exp_u});
    check("synced", {31'd0, synced}, {31'd0, m_synced});
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("pal_active", {31'd0, pal_active}, {31'd0, e[6]});
      check("pal_addr", {26'd0, pal_addr}, {26'd0, e[5:0]});
    end else begin
      check("pal_addr_hold", {26'd0, pal_addr}, 32'd0);
      check("pal_active_hold", {31'd0, pal_active}, 32'd0);
    end
    if (exp_u) begin
      tick();
      check("underrun_pulse_end", {31'd0, underrun}, 32'd0);
    end
  endtask

  task automatic vga_row(input int y, input bit full);
    vga_tick(0, y);
    if (full) begin
      for (int x = 60; x <= 580; x++) vga_tick(x, y);
    end else begin
      vga_tick(62, y); vga_tick(63, y); vga_tick(64, y); vga_tick(65, y);
      vga_tick(66, y); vga_tick(67, y);
      for (int i = 0; i < 3; i++) vga_tick(int'($urandom_range(64, 575)), y);
      vga_tick(574, y); vga_tick(575, y); vga_tick(576, y); vga_tick(577, y);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
    check({tag, "_pal_addr"}, {26'd0, pal_addr}, 32'd0);
    check({tag, "_pal_active"}, {31'd0, pal_active}, 32'd0);
    check({tag, "_synced"}, {31'd0, synced}, 32'd0);
    check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
  endtask

  task automatic model_reset();
    comp_q.delete();
    exp_q.delete();
    showing  = -1;
    m_synced = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      line_sof[i] = 1'b0;
      for (int x = 0; x < 256; x++)
        line_mem[i][x] = (i == 0) ? 6'(x) : 6'($urandom_range(0, 63));
    end
    line_sof[0] = 1'b1; line_sof[6] = 1'b1; line_sof[8] = 1'b1;
    line_sof[10] = 1'b1; line_sof[11] = 1'b1;

    // Clock/reset
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    model_reset();
    check_reset_outputs("reset");
    repeat (3) begin
      tick();
      check("reset_underrun_idle", {31'd0, underrun}, 32'd0);
    end

    // Fill both banks; the second full line leaves no free bank
    write_line(0);
    write_line(1);
    check("wr_ready_backpressure", {31'd0, wr_ready}, {31'd0, model_ready()});

    // Frame start takes the sof line; DrawY=1 repeats it
    vga_row(0, 1'b1);
    vga_row(1, 1'b0);
    check("wr_ready_still_blocked", {31'd0, wr_ready}, {31'd0, model_ready()});
    vga_row(2, 1'b0);
    check("wr_ready_after_free", {31'd0, wr_ready}, {31'd0, model_ready()});
    vga_row(3, 1'b0);
    write_line(2);
    vga_row(4, 1'b1);
    vga_row(5, 1'b0);

    // Underrun: nothing buffered at the next pair start
    vga_row(6, 1'b0);
    vga_row(7, 1'b0);
    write_line(3);
    vga_row(8, 1'b0);

    // Resync: a non-sof line at DrawY=0 drops sync for the whole frame
    write_line(4);
    vga_row(0, 1'b0);
    vga_row(1, 1'b0);
    vga_row(100, 1'b0);
    write_line(5);
    vga_row(2, 1'b0);
    write_line(6);
    write_line(7);
    check("wr_ready_held_sof", {31'd0, wr_ready}, {31'd0, model_ready()});
    vga_row(4, 1'b0);
    vga_row(478, 1'b0);
    vga_row(479, 1'b0);
    vga_row(480, 1'b0);
    vga_row(0, 1'b1);
    vga_row(2, 1'b0);
    vga_row(3, 1'b0);

    // Underrun mid-frame, then at frame start (which also loses sync)
    vga_row(4, 1'b0);
    vga_row(0, 1'b0);
    vga_row(1, 1'b0);

    // Reset in the middle of a line write
    write_line(8);
    write_line(9);
    vga_row(0, 1'b0);
    vga_row(2, 1'b0);
    check("synced_before_reset", {31'd0, synced}, 32'd1);
    write_pixels(10, 0, 99);
    wr_valid = 1'b1;
    wr_x     = 8'd100;
    wr_index = line_mem[10][100];
    wr_sof   = line_sof[10];
    Reset    = 1'b1;
    tick();
    check_reset_outputs("midline_reset");
    Reset    = 1'b0;
    wr_valid = 1'b0;
    model_reset();

    // A fresh sof line after reset displays correctly
    write_line(11);
    write_line(12);
    vga_row(0, 1'b1);
    vga_row(1, 1'b0);
    vga_row(2, 1'b0);
    vga_tick(799, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/nes_line_doubler.md
# nes_line_doubler

Buffers PPU scanlines and scan-doubles them for VGA output. The PPU writes 256-pixel lines of 6-bit palette indices into two ping-pong line banks. The VGA read side replays each line on two consecutive VGA lines, inside a 512x480 window centred in 640x480, and emits the 6-bit palette address consumed by nes_color_rom. Back-pressure paces the PPU; a start-of-frame tag keeps PPU line 0 aligned with VGA line 0.

## Interface
- H_OFFSET, 64: first DrawX of the 512-pixel window.
- BORDER_INDEX, 6'h0F: palette index driven outside the window or when no line is available (black).

- Clk  in  1  system clock; all logic is single-clock.
- Reset  in  1  synchronous, active-high.
- wr_valid  in  1  PPU pixel strobe.
- wr_ready  out  1  pixel accepted when wr_valid & wr_ready.
- wr_x  in  8  pixel column 0..255.
- wr_sof  in  1  qualifies the x=0 pixel as PPU line 0 of a frame.
- wr_index  in  6  palette index.
- pix_ce  in  1  VGA pixel enable; the read pipeline advances only on it.
- DrawX  in  10  VGA column 0..799.
- DrawY  in  10  VGA row 0..524.
- pal_addr  out  6  to color ROM addr.
- pal_active  out  1  pal_addr comes from buffered PPU data.
- underrun  out  1  one-Clk pulse when a line pair repeats for lack of data.
- synced  out  1  a sof-tagged line was taken at DrawY==0 and the frame is being shown.

## Operation
- Banks: two 256x6 RAMs, each with state FREE/FILLING/FULL/READING plus a sof bit.
- Write FSM: wr_bank starts at 0.
  - wr_ready = (state[wr_bank] is FREE or FILLING).
  - An accepted pixel writes RAM[wr_bank][wr_x]. At wr_x==0 it captures wr_sof and sets the bank to FILLING.
  - An accepted pixel at wr_x==255 sets the bank to FULL and toggles wr_bank.
  - Pixels must arrive in order; out-of-order columns are written without checks.
- Pair start: a pix_ce cycle with DrawX==0, DrawY[0]==0 and DrawY<480. Decisions use bank state registered before that cycle. "Other" = the bank not READING.
  - DrawY==0: the READING bank (if any) becomes FREE.
    - If other is FULL with sof=1, it becomes READING and synced=1.
    - If other is FULL with sof=0, it becomes FREE, synced=0, and the pair shows border.
    - If other is not FULL, synced=0 and the pair shows border; underrun pulses if synced was 1.
  - DrawY>0, synced=1:
    - If other is FULL with sof=0, the READING bank becomes FREE and other becomes READING.
    - If other is FULL with sof=1 (PPU ahead), the current bank repeats.
    - If other is not FULL, the current bank repeats and underrun pulses.
  - DrawY>0, synced=0: a FULL sof=0 bank becomes FREE; a FULL sof=1 bank is held for the next DrawY==0; the pair shows border.
- Window: in_win = DrawX in [H_OFFSET, H_OFFSET+511] and DrawY<480 and a READING bank exists.
  - Read address = (DrawX-H_OFFSET)>>1, 9-bit subtraction, low 8 bits used.
- Output: pal_addr = RAM data when in_win, else BORDER_INDEX. pal_active = in_win.

## Timing
- Reset values:
  - all banks FREE; wr_bank=0; no READING bank.
  - wr_ready=1, pal_addr=6'h00, pal_active=0, underrun=0, synced=0.
  - pal_addr/pal_active hold 0 until the second pix_ce after reset.
- Read latency: exactly 2 pix_ce ticks from DrawX/DrawY sample to pal_addr/pal_active. The VGA controller delays its syncs by 2 ticks to match.
- Stage 1 registers in_win and the RAM address. Stage 2 is the synchronous RAM read plus output mux.
- Write/read collision: RAM is true dual-port. The write side never targets the READING bank, so there is no read-during-write hazard.
- A bank reaching FULL in the same cycle as a pair start is not seen until the next pair start.
- wr_ready deasserts the cycle after the x=255 pixel if the next bank is not FREE.
- A bank freed at pair start makes wr_ready=1 on the following cycle.
- Reset mid-line discards both banks. Any partially written line is lost, and the write side restarts at bank 0.

## Test plan
- Reset → wr_ready=1, pal_addr=0, pal_active=0, synced=0, underrun=0 held.
- Write line0 (sof=1, index=x[5:0]) and line1, then sweep DrawY=0 → synced=1.
  - DrawX=64 gives pal_addr=0x00 two ticks later; DrawX=65 gives 0x00; DrawX=66 gives 0x01; DrawX=575 gives 0x3F.
  - DrawX=63 and 576 give 0x0F with pal_active=0. DrawY=1 repeats identical values.
- Back-pressure: write 3 lines with no VGA pair start → wr_ready=0 after line1's x=255. Line2 pixels are not accepted until the DrawY=2 pair start frees line0's bank.
- Underrun: synced, no FULL bank at DrawY=2 → underrun high exactly one Clk, and DrawY=2/3 show line0 data again.
- Resync: FULL sof=0 bank at DrawY=0 → bank freed, whole frame border (0x0F), synced=0.
  - A sof line arriving mid-frame is held and taken at the next DrawY=0, giving synced=1.
- Reset asserted mid-line during a write at x=100 → next cycle all outputs return to reset values, and a fresh line with sof displays correctly.
